ml_operand_loader: RTL and testbench

//  Upstream stage of the ML accelerator control FSM. Collects a byte stream from the UART/FIFO

---
 rtl/ml_operand_loader.sv | 203 ++++++++++++++++++++
 tb/tb_ml_operand_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_operand_loader.sv
// ml_operand_loader
// Assembles a little-endian byte stream into a VEC_LEN-entry operand buffer.
// data_ready is raised once a full vector is stored. The compute engine reads
// operands by index, with one cycle of latency. A release pulse frees the
// buffer for the next vector.
// Optional feature: define CHECKSUM_EN to add a trailing XOR checksum byte per
// vector. When it is defined, the loader adds a CHECK state and a sticky chk_err
// output.
// The vector-consumed pulse is called release_pulse because release is a
// reserved word in SystemVerilog.
`timescale 1ns/1ps

module ml_operand_loader #(
    parameter int WORD_BYTES = 2,
    parameter int VEC_LEN    = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_ready,
    input  logic                    flush,
    input  logic                    release_pulse,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic                    data_ready,
    output logic [ADDR_W:0]         word_cnt,
    output logic                    chk_err
);

    localparam int                WORD_W    = 8 * WORD_BYTES;
    localparam int                BI_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(VEC_LEN - 1);
    localparam logic [ADDR_W:0]   VEC_LEN_C = (ADDR_W + 1)'(VEC_LEN);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_CHECK, ST_FULL} state_e;
`else
    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL} state_e;
`endif

    state_e              state_q, state_d;
    logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic                data_ready_q, data_ready_d;
    logic [WORD_W-1:0]   rd_data_q, rd_data_d;
    logic                buf_we;
    logic [ADDR_W-1:0]   buf_waddr;
    logic [WORD_W-1:0]   buf_q [VEC_LEN];
`ifdef CHECKSUM_EN
    logic [7:0]          chk_acc_q, chk_acc_d;
    logic                chk_err_q, chk_err_d;
`endif

    // Upstream may only transfer while a vector is not being held.
    assign rx_ready = (state_q != ST_FULL);

    // Next-state, byte-lane assembly, buffer write enable and read mux.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        buf_we     = 1'b0;
        buf_waddr  = word_cnt_q[ADDR_W-1:0];
`ifdef CHECKSUM_EN
        chk_acc_d  = chk_acc_q;
        chk_err_d  = chk_err_q;
`endif

        if ({1'b0, rd_addr} < VEC_LEN_C) begin
            rd_data_d = buf_q[rd_addr];
        end else begin
            rd_data_d = '0;
        end

        if (flush) begin
            // Drops any partial or full vector; a same-cycle byte is lost.
            state_d    = ST_EMPTY;
            byte_idx_d = '0;
            word_cnt_d = '0;
            asm_d      = '0;
`ifdef CHECKSUM_EN
            chk_acc_d  = '0;
            chk_err_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_EMPTY, ST_FILL: begin
                    if (rx_valid) begin
                        state_d = ST_FILL;
                        for (int i = 0; i < WORD_BYTES; i++) begin
                            if (byte_idx_q == BI_W'(i)) begin
                                asm_d[8*i +: 8] = rx_data;
                            end
                        end
`ifdef CHECKSUM_EN
                        chk_acc_d = chk_acc_q ^ rx_data;
`endif
                        if (byte_idx_q == LAST_BYTE) begin
                            // Word complete: committed together with its last byte.
                            byte_idx_d = '0;
                            buf_we     = 1'b1;
                            word_cnt_d = word_cnt_q + 1'b1;
                            if (word_cnt_q == LAST_WORD) begin
`ifdef CHECKSUM_EN
                                state_d = ST_CHECK;
`else
                                state_d = ST_FULL;
`endif
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
`ifdef CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_acc_q) begin
                            state_d = ST_FULL;
                        end else begin
                            // Bad vector never reaches FULL; the error stays until flush/reset.
                            chk_err_d  = 1'b1;
                            state_d    = ST_EMPTY;
                            byte_idx_d = '0;
                            word_cnt_d = '0;
                            asm_d      = '0;
                            chk_acc_d  = '0;
                        end
                    end
                end
`endif
                ST_FULL: begin
                    if (release_pulse) begin
                        state_d    = ST_EMPTY;
                        byte_idx_d = '0;
                        word_cnt_d = '0;
                        asm_d      = '0;
`ifdef CHECKSUM_EN
                        chk_acc_d  = '0;
`endif
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        data_ready_d = (state_d == ST_FULL);
    end

    // Control state, assembly register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            byte_idx_q   <= '0;
            word_cnt_q   <= '0;
            asm_q        <= '0;
            data_ready_q <= 1'b0;
            rd_data_q    <= '0;
`ifdef CHECKSUM_EN
            chk_acc_q    <= '0;
            chk_err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_cnt_q   <= word_cnt_d;
            asm_q        <= asm_d;
            data_ready_q <= data_ready_d;
            rd_data_q    <= rd_data_d;
`ifdef CHECKSUM_EN
            chk_acc_q    <= chk_acc_d;
            chk_err_q    <= chk_err_d;
`endif
        end
    end

    // Operand storage; written once per completed word.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; its contents are only meaningful once written, and a plain RAM is cheaper.
        if (buf_we) begin
            buf_q[buf_waddr] <= asm_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign data_ready = data_ready_q;
    assign word_cnt   = word_cnt_q;
`ifdef CHECKSUM_EN
    assign chk_err    = chk_err_q;
`else
    assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ml_operand_loader.sv
// tb_ml_operand_loader
// Directed scenarios followed by random traffic. Each cycle is checked against
// a byte-queue reference model of the operand loader. Build with CHECKSUM_EN
// defined to exercise the checksum variant.
`timescale 1ns/1ps

module tb_ml_operand_loader;

    localparam int WB = 2;
    localparam int VL = 4;
    localparam int AW = 2;
`ifdef CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = '0;
    logic            rx_ready;
    logic            flush = 1'b0;
    logic            rel = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic [8*WB-1:0] rd_data;
    logic            data_ready;
    logic [AW:0]     word_cnt;
    logic            chk_err;

    int checks = 0;
    int failures = 0;

    ml_operand_loader #(.WORD_BYTES(WB), .VEC_LEN(VL), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .flush        (flush),
        .release_pulse(rel),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .data_ready   (data_ready),
        .word_cnt     (word_cnt),
        .chk_err      (chk_err)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the vector in progress, held-vector flag, buffer image.
    byte unsigned m_cur[$];
    bit           m_full;
    bit           m_chk_err;
    logic [15:0]  m_buf[VL];
    bit           m_bv[VL];
    logic [15:0]  m_rd;
    bit           m_rd_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic byte unsigned cur_xor();
        byte unsigned x = 0;
        foreach (m_cur[i]) x ^= m_cur[i];
        return x;
    endfunction

    task automatic model_reset();
        m_cur.delete();
        m_full = 0;
        m_chk_err = 0;
        m_rd = '0;
        m_rd_v = 1;
        for (int i = 0; i < VL; i++) m_bv[i] = 0;
    endtask

    task automatic model_edge(input bit v, input byte unsigned d, input bit fl, input bit rl,
                              input int a);
        int idx;
        logic [15:0] w;
        if (a < VL) begin
            m_rd = m_buf[a];
            m_rd_v = m_bv[a];
        end else begin
            m_rd = '0;
            m_rd_v = 1;
        end
        if (fl) begin
            m_cur.delete();
            m_full = 0;
            m_chk_err = 0;
        end else if (m_full) begin
            if (rl) begin
                m_full = 0;
                m_cur.delete();
            end
        end else if (v) begin
            if (m_cur.size() < VL * WB) begin
                m_cur.push_back(d);
                if (m_cur.size() % WB == 0) begin
                    idx = m_cur.size() / WB - 1;
                    w = '0;
                    for (int k = 0; k < WB; k++) w = w | (16'(m_cur[idx*WB+k]) << (8 * k));
                    m_buf[idx] = w;
                    m_bv[idx] = 1;
                end
                if (m_cur.size() == VL * WB && !CK) m_full = 1;
            end else begin
                if (cur_xor() == d) begin
                    m_full = 1;
                end else begin
                    m_chk_err = 1;
                    m_cur.delete();
                end
            end
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs at the next falling edge.
    task automatic step(input bit v, input byte unsigned d, input bit fl, input bit rl, input int a);
        rx_valid = v;
        rx_data  = d;
        flush    = fl;
        rel      = rl;
        rd_addr  = AW'(a);
        #1;
        check("rx_ready", 32'(rx_ready), 32'(!m_full));
        @(posedge clk);
        model_edge(v, d, fl, rl, a);
        @(negedge clk);
        check("data_ready", 32'(data_ready), 32'(m_full));
        check("word_cnt", 32'(word_cnt), 32'(m_cur.size() / WB));
        check("chk_err", 32'(chk_err), 32'(m_chk_err));
        if (m_rd_v) check("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic send_bytes(input int n, input logic [63:0] data, input int a);
        logic [63:0] dd;
        dd = data;
        for (int i = 0; i < n; i++) step(1, dd[8*i +: 8], 0, 0, a);
    endtask

    task automatic send_ck(input bit good, input int a);
`ifdef CHECKSUM_EN
        byte unsigned x;
        x = cur_xor();
        step(1, good ? x : (x ^ 8'h01), 0, 0, a);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_data_ready", 32'(data_ready), 32'h0);
        check("reset_word_cnt", 32'(word_cnt), 32'h0);
        check("reset_rd_data", 32'(rd_data), 32'h0);
        reset_n = 1'b1;
        #1;
        check("reset_rx_ready", 32'(rx_ready), 32'h1);

        // 1: reset asserted in the middle of a vector.
        send_bytes(3, 64'h0000_0000_0033_2211, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_data_ready", 32'(data_ready), 32'h0);
        check("t1_word_cnt", 32'(word_cnt), 32'h0);
        check("t1_rd_data", 32'(rd_data), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("t1_rx_ready", 32'(rx_ready), 32'h1);

        // 2: full vector fill, then read index 2.
        send_bytes(8, 64'h0004_0003_0002_0001, 2);
        send_ck(1, 2);
        check("t2_data_ready", 32'(data_ready), 32'h1);
        check("t2_rx_ready", 32'(rx_ready), 32'h0);
        step(0, 8'h00, 0, 0, 2);
        check("t2_rd_data", 32'(rd_data), 32'h0003);

        // 3: backpressure while full, then release with the byte still offered.
        for (int i = 0; i < 5; i++) step(1, 8'hAA, 0, 0, i % VL);
        check("t3_word_cnt_held", 32'(word_cnt), 32'(VL));
        step(1, 8'hAA, 0, 1, 1);
        check("t3_released_cnt", 32'(word_cnt), 32'h0);
        check("t3_released_dr", 32'(data_ready), 32'h0);
        step(1, 8'hAA, 0, 0, 0);
        step(1, 8'h11, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        check("t3_first_word", 32'(rd_data), 32'h11AA);
        send_bytes(6, 64'h0000_6655_4433_2211, 0);
        send_ck(1, 0);
        check("t3_full_again", 32'(data_ready), 32'h1);

        // 4: flush after three bytes with a byte offered in the flush cycle.
        step(0, 8'h00, 0, 1, 0);
        send_bytes(3, 64'h0000_0000_00C3_B2A1, 0);
        step(1, 8'hEE, 1, 0, 0);
        check("t4_flush_cnt", 32'(word_cnt), 32'h0);
        send_bytes(8, 64'h8877_6655_4433_2211, 0);
        send_ck(1, 0);
        step(0, 8'h00, 0, 0, 0);
        check("t4_fresh_word0", 32'(rd_data), 32'h2211);
        check("t4_full", 32'(data_ready), 32'h1);

        // 5: release outside FULL has no effect.
        step(0, 8'h00, 0, 1, 0);
        send_bytes(4, 64'h0000_0000_0D0C_0B0A, 1);
        step(0, 8'h00, 0, 1, 1);
        check("t5_word_cnt", 32'(word_cnt), 32'h2);
        send_bytes(4, 64'h0000_0000_1110_0F0E, 1);
        send_ck(1, 1);
        check("t5_full", 32'(data_ready), 32'h1);

`ifdef CHECKSUM_EN
        // 6: good and bad checksum bytes.
        step(0, 8'h00, 0, 1, 0);
        send_bytes(8, 64'h0004_0003_0002_0001, 0);
        step(1, 8'h04, 0, 0, 0);
        check("t6_good_full", 32'(data_ready), 32'h1);
        step(0, 8'h00, 0, 1, 0);
        send_bytes(8, 64'h0004_0003_0002_0001, 0);
        step(1, 8'h05, 0, 0, 0);
        check("t6_bad_err", 32'(chk_err), 32'h1);
        check("t6_bad_dr", 32'(data_ready), 32'h0);
        check("t6_bad_cnt", 32'(word_cnt), 32'h0);
        step(0, 8'h00, 1, 0, 0);
        check("t6_flush_err", 32'(chk_err), 32'h0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          v, fl, rl;
            byte unsigned d;
            v  = ($urandom % 10) < 7;
            d  = 8'($urandom);
            if (CK && !m_full && m_cur.size() == VL * WB && ($urandom % 2) == 1) d = cur_xor();
            fl = ($urandom % 40) == 0;
            rl = ($urandom % 8) == 0;
            step(v, d, fl, rl, int'($urandom % VL));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
